somador_serial: RTL and testbench



---
 rtl/somador_serial.sv | 163 ++++++++++++++++
 tb/tb_somador_serial.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/somador_serial.sv
`default_nettype none
// ============================================================================
// Module      : somador_serial
// Description : Multi-cycle adder/subtractor that reuses a STEP-bit carry chain
//               for WIDTH/STEP clocks, with a start/busy/done handshake.
//               Define SOMADOR_SERIAL_FLAGS_EN to add the zero/neg result flags.
// Revision    : 1.0 - initial release
// ============================================================================
module somador_serial #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef SOMADOR_SERIAL_FLAGS_EN
    output logic             zero,
    output logic             neg,
`endif
    output logic             ovf
);

    localparam int K     = WIDTH / STEP;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);

    generate
        if (WIDTH < 2 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_params
            $error("somador_serial: WIDTH must be >= 2 and STEP must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic [STEP:0]    w_sum;
    logic             w_cmsb;

    assign w_sum = {1'b0, a_q[STEP-1:0]} + {1'b0, b_q[STEP-1:0]} + {{STEP{1'b0}}, carry_q};

    // Carry into the top bit of the slice; on the last slice this is the carry into the MSB.
    generate
        if (STEP == 1) begin : g_cmsb_single
            assign w_cmsb = carry_q;
        end else begin : g_cmsb_multi
            logic [STEP-1:0] w_low;
            assign w_low  = {1'b0, a_q[STEP-2:0]} + {1'b0, b_q[STEP-2:0]}
                          + {{(STEP-1){1'b0}}, carry_q};
            assign w_cmsb = w_low[STEP-1];
        end
    endgenerate

    // Sum bits enter the vacated top of the A register, so after K steps it holds the result.
    generate
        if (STEP == WIDTH) begin : g_shift_full
            assign a_d = w_sum[STEP-1:0];
            assign b_d = '0;
        end else begin : g_shift_part
            assign a_d = {w_sum[STEP-1:0], a_q[WIDTH-1:STEP]};
            assign b_d = {{STEP{1'b0}}, b_q[WIDTH-1:STEP]};
        end
    endgenerate

`ifdef SOMADOR_SERIAL_FLAGS_EN
    logic zero_q;
    logic neg_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SOMADOR_SERIAL_FLAGS_EN
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    carry_q <= w_sum[STEP];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        s_q     <= a_d;
                        cout_q  <= w_sum[STEP];
                        ovf_q   <= w_cmsb ^ w_sum[STEP];
`ifdef SOMADOR_SERIAL_FLAGS_EN
                        zero_q  <= (a_d == '0);
                        neg_q   <= a_d[WIDTH-1];
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
`ifdef SOMADOR_SERIAL_FLAGS_EN
    assign zero = zero_q;
    assign neg  = neg_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_somador_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_somador_serial
// Description : Self-checking bench driving four somador_serial configurations
//               in lockstep (8/1, 8/2, 32/4, 32/32) against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_somador_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [3:0]  cout_v;
    logic [3:0]  ovf_v;
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic [31:0] s2;
    logic [31:0] s3;
`ifdef SOMADOR_SERIAL_FLAGS_EN
    logic [3:0]  zero_v;
    logic [3:0]  neg_v;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    somador_serial #(.WIDTH(8), .STEP(1)) u_w8s1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .s(s0), .cout(cout_v[0]),
`ifdef SOMADOR_SERIAL_FLAGS_EN
        .zero(zero_v[0]), .neg(neg_v[0]),
`endif
        .ovf(ovf_v[0]));

    somador_serial #(.WIDTH(8), .STEP(2)) u_w8s2 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .s(s1), .cout(cout_v[1]),
`ifdef SOMADOR_SERIAL_FLAGS_EN
        .zero(zero_v[1]), .neg(neg_v[1]),
`endif
        .ovf(ovf_v[1]));

    somador_serial #(.WIDTH(32), .STEP(4)) u_w32s4 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[2]), .done(done_v[2]), .s(s2), .cout(cout_v[2]),
`ifdef SOMADOR_SERIAL_FLAGS_EN
        .zero(zero_v[2]), .neg(neg_v[2]),
`endif
        .ovf(ovf_v[2]));

    somador_serial #(.WIDTH(32), .STEP(32)) u_w32s32 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[3]), .done(done_v[3]), .s(s3), .cout(cout_v[3]),
`ifdef SOMADOR_SERIAL_FLAGS_EN
        .zero(zero_v[3]), .neg(neg_v[3]),
`endif
        .ovf(ovf_v[3]));

    function automatic int wv(int i);
        return (i < 2) ? 8 : 32;
    endfunction

    function automatic int kv(int i);
        case (i)
            0:       return 8;
            1:       return 4;
            2:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] s_of(int i);
        case (i)
            0:       return {24'd0, s0};
            1:       return {24'd0, s1};
            2:       return s2;
            default: return s3;
        endcase
    endfunction

    // Reference: plain modulo arithmetic; ovf from the two's-complement sign rule.
    function automatic logic [33:0] model(int w, logic op_sub, logic op_cin,
                                          logic [31:0] op_a, logic [31:0] op_b);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bm;
        logic [63:0] tot;
        logic [63:0] sr;
        logic        co;
        logic        ov;
        mask = (64'd1 << w) - 64'd1;
        am   = {32'd0, op_a} & mask;
        bm   = {32'd0, (op_sub ? ~op_b : op_b)} & mask;
        tot  = am + bm + {63'd0, (op_sub ? 1'b1 : op_cin)};
        sr   = tot & mask;
        co   = tot[w];
        ov   = (am[w-1] == bm[w-1]) && (sr[w-1] != am[w-1]);
        return {ov, co, sr[31:0]};
    endfunction

    task automatic chk_b(string nm, int inst, logic act, logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s inst%0d: got %b expected %b at %0t", nm, inst, act, want, $time);
        end
    endtask

    task automatic chk_w(string nm, int inst, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, inst, act, want, $time);
        end
    endtask

    typedef struct {
        logic       sub;
        logic       cin;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] prev_s [4];
    logic        prev_c [4];
    logic        prev_o [4];
    logic [31:0] new_s  [4];
    logic        new_c  [4];
    logic        new_o  [4];
    logic        prev_z [4];
    logic        prev_n [4];

    task automatic clear_prev();
        for (int i = 0; i < 4; i++) begin
            prev_s[i] = '0;
            prev_c[i] = 1'b0;
            prev_o[i] = 1'b0;
            prev_z[i] = 1'b0;
            prev_n[i] = 1'b0;
        end
    endtask

    task automatic chk_all_zero(string nm);
        for (int i = 0; i < 4; i++) begin
            chk_b({nm, "_busy"}, i, busy_v[i], 1'b0);
            chk_b({nm, "_done"}, i, done_v[i], 1'b0);
            chk_w({nm, "_s"}, i, s_of(i), 32'd0);
            chk_b({nm, "_cout"}, i, cout_v[i], 1'b0);
            chk_b({nm, "_ovf"}, i, ovf_v[i], 1'b0);
`ifdef SOMADOR_SERIAL_FLAGS_EN
            chk_b({nm, "_zero"}, i, zero_v[i], 1'b0);
            chk_b({nm, "_neg"}, i, neg_v[i], 1'b0);
`endif
        end
    endtask

    // One operation on all four instances; stray start pulses and operand churn follow it.
    task automatic do_op(logic op_sub, logic op_cin, logic [31:0] op_a, logic [31:0] op_b,
                         logic use_tbl, logic [7:0] ts, logic tc, logic to);
        logic [33:0] r;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk_b("idle_busy", i, busy_v[i], 1'b0);
            chk_b("idle_done", i, done_v[i], 1'b0);
            chk_w("idle_hold_s", i, s_of(i), prev_s[i]);
            r = model(wv(i), op_sub, op_cin, op_a, op_b);
            new_s[i] = r[31:0];
            new_c[i] = r[32];
            new_o[i] = r[33];
            if (use_tbl && wv(i) == 8) begin
                new_s[i] = {24'd0, ts};
                new_c[i] = tc;
                new_o[i] = to;
            end
        end
        sub   = op_sub;
        cin   = op_cin;
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                logic fin;
                fin = (c > kv(i));
                chk_b("busy", i, busy_v[i], c <= kv(i));
                chk_b("done", i, done_v[i], c == kv(i) + 1);
                chk_w("s", i, s_of(i), fin ? new_s[i] : prev_s[i]);
                chk_b("cout", i, cout_v[i], fin ? new_c[i] : prev_c[i]);
                chk_b("ovf", i, ovf_v[i], fin ? new_o[i] : prev_o[i]);
`ifdef SOMADOR_SERIAL_FLAGS_EN
                chk_b("zero", i, zero_v[i], fin ? (new_s[i] == 32'd0) : prev_z[i]);
                chk_b("neg", i, neg_v[i], fin ? new_s[i][wv(i)-1] : prev_n[i]);
`endif
            end
            a     = $urandom;
            b     = $urandom;
            sub   = 1'($urandom);
            cin   = 1'($urandom);
            start = (c <= 2);
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            prev_s[i] = new_s[i];
            prev_c[i] = new_c[i];
            prev_o[i] = new_o[i];
            prev_z[i] = (new_s[i] == 32'd0);
            prev_n[i] = new_s[i][wv(i)-1];
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        tbl[0] = '{1'b0, 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'h20, 8'h10, 8'h10, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        clear_prev();

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        for (int t = 0; t < 8; t++)
            do_op(tbl[t].sub, tbl[t].cin, {24'd0, tbl[t].a}, {24'd0, tbl[t].b},
                  1'b1, tbl[t].s, tbl[t].cout, tbl[t].ovf);

        // Reset landing on the fourth RUN edge of the 8-cycle instances.
        @(negedge clk);
        a     = 32'h35;
        b     = 32'h4A;
        sub   = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("midrun_rst");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_w("post_rst_quiet", -1, {24'd0, busy_v, done_v}, 32'd0);
        end
        clear_prev();
        do_op(1'b0, 1'b0, 32'h35, 32'h4A, 1'b1, 8'h7F, 1'b0, 1'b0);

        for (int n = 0; n < 1000; n++)
            do_op(1'($urandom), 1'($urandom), $urandom, $urandom, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
